// File: rtl/drm_pkg.sv
// ============================================================================
// Module   : drm_pkg
// Purpose  : Shared widths, pointer type and pointer arithmetic for the
//            DRM simple-dual-port FIFO read path.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package drm_pkg;

  localparam int DRM_ADDR_WIDTH = 8;
  localparam int DRM_DATA_WIDTH = 34;

  // Extra msb is the wrap bit that tells full from empty.
  typedef logic [DRM_ADDR_WIDTH:0] ptr_t;

  function automatic ptr_t ptr_diff(input ptr_t a, input ptr_t b);
    return a - b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/drm_skid_buf.sv
// ============================================================================
// Module   : drm_skid_buf
// Purpose  : Two-entry valid/ready output buffer (head + skid) with a capture
//            input from the RAM and a free-slot count for the issue logic.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module drm_skid_buf
  import drm_pkg::*;
#(
  parameter int DATA_WIDTH = DRM_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  cap_valid_i,
  input  logic [DATA_WIDTH-1:0] cap_data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic [1:0]            free_o
);

  logic [1:0]            cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] skid_q, skid_d;

  // pop_i is already qualified with valid_o by the parent.
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush_i) begin
      cnt_d = 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (cap_valid_i) begin
            head_d = cap_data_i;
            cnt_d  = 2'd1;
          end
        end
        2'd1: begin
          if (pop_i && cap_valid_i) begin
            head_d = cap_data_i;
          end else if (pop_i) begin
            cnt_d = 2'd0;
          end else if (cap_valid_i) begin
            skid_d = cap_data_i;
            cnt_d  = 2'd2;
          end
        end
        default: begin
          if (pop_i) begin
            head_d = skid_q;
            if (cap_valid_i) begin
              skid_d = cap_data_i;
            end else begin
              cnt_d = 2'd1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = head_q;
  assign free_o  = 2'd2 - cnt_q;

endmodule

`default_nettype wire

// File: rtl/drm_sdp_stream_reader.sv
// ============================================================================
// Module   : drm_sdp_stream_reader
// Purpose  : Read-side controller turning the 34x256 SDP RAM into a streaming
//            FIFO read port with prefetch, flush and consumed-pointer return.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module drm_sdp_stream_reader
  import drm_pkg::*;
#(
  parameter int ADDR_WIDTH  = DRM_ADDR_WIDTH,
  parameter int DATA_WIDTH  = DRM_DATA_WIDTH,
  parameter int RAM_LATENCY = 1
) (
  input  logic                  rd_clk_i,
  input  logic                  rd_rst_n_i,
  input  logic [ADDR_WIDTH:0]   wr_ptr_i,
  output logic [ADDR_WIDTH:0]   rd_ptr_o,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i,
  input  logic                  flush_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic [ADDR_WIDTH:0]   level_o
);

  logic [ADDR_WIDTH:0] iptr_q, iptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          free;
  logic                pop, avail, issue, cap;
  logic [2:0]          demand;

  assign pop   = m_valid_o & m_ready_i;
  assign avail = (iptr_q != wr_ptr_i);
  // Only the single-cycle RAM read path exists; the returning word is the in-flight one.
  assign cap   = inflight_q & (RAM_LATENCY == 1);

  // Slots that will be spoken for after this cycle's pop, counting the word in flight.
  assign demand = 3'd2 - {1'b0, free} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue  = avail & (demand < 3'd2);

  always_comb begin
    iptr_d     = iptr_q;
    rd_ptr_d   = rd_ptr_q;
    inflight_d = 1'b0;
    if (flush_i) begin
      iptr_d   = wr_ptr_i;
      rd_ptr_d = wr_ptr_i;
    end else begin
      if (issue) begin
        iptr_d     = iptr_q + 1'b1;
        inflight_d = 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge rd_clk_i) begin
    if (!rd_rst_n_i) begin
      iptr_q     <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      iptr_q     <= iptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  drm_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .clk_i       (rd_clk_i),
    .rst_ni      (rd_rst_n_i),
    .flush_i     (flush_i),
    .cap_valid_i (cap),
    .cap_data_i  (ram_rd_data_i),
    .pop_i       (pop),
    .valid_o     (m_valid_o),
    .data_o      (m_data_o),
    .free_o      (free)
  );

  assign ram_rd_addr_o = iptr_q[ADDR_WIDTH-1:0];
  assign rd_ptr_o      = rd_ptr_q;
  assign level_o       = ptr_diff(wr_ptr_i, rd_ptr_q);

endmodule

`default_nettype wire

// File: tb/tb_drm_sdp_stream_reader.sv
// ============================================================================
// Module   : tb_drm_sdp_stream_reader
// Purpose  : Directed self-checking bench for drm_sdp_stream_reader with a
//            behavioural SDP RAM and writer model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_drm_sdp_stream_reader;

  localparam int AW = 8;
  localparam int DW = 34;

  logic          clk     = 1'b0;
  logic          rst_n   = 1'b0;
  logic [AW:0]   wr_ptr  = '0;
  logic          flush   = 1'b0;
  logic          m_ready = 1'b0;
  logic [AW:0]   rd_ptr;
  logic [AW-1:0] addr;
  logic [DW-1:0] rdata;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic [AW:0]   level;
  logic [DW-1:0] mem [0:255];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  always @(posedge clk) rdata <= mem[addr];

  drm_sdp_stream_reader dut (
    .rd_clk_i      (clk),
    .rd_rst_n_i    (rst_n),
    .wr_ptr_i      (wr_ptr),
    .rd_ptr_o      (rd_ptr),
    .ram_rd_addr_o (addr),
    .ram_rd_data_i (rdata),
    .flush_i       (flush),
    .m_valid_o     (m_valid),
    .m_data_o      (m_data),
    .m_ready_i     (m_ready),
    .level_o       (level)
  );

  function automatic logic [DW-1:0] pat(input int k);
    logic [DW-1:0] v;
    v = DW'(k);
    return v ^ 34'h2_5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int            n;
    int            first_c;
    int            wn;
    int            rn;
    logic          stalled;
    logic [DW-1:0] held;
    logic [AW:0]   used;

    for (int i = 0; i < 256; i++) mem[i] = pat(i);

    // Reset with a non-empty writer pointer
    rst_n = 1'b0; wr_ptr = 9'd5; m_ready = 1'b0;
    tick(); tick();
    check("rst_valid", m_valid, 1'b0);
    check("rst_rdptr", rd_ptr, 9'd0);
    check("rst_level", level, 9'd5);
    check("rst_addr", addr, 8'd0);
    check("rst_data", m_data, 34'd0);
    rst_n = 1'b1;
    tick();
    check("lat_c1_valid", m_valid, 1'b0);
    check("lat_c1_addr", addr, 8'd1);
    tick();
    check("lat_c2_valid", m_valid, 1'b1);
    check("lat_c2_data", m_data, pat(0));
    tick();
    check("stall_data", m_data, pat(0));
    check("stall_rdptr", rd_ptr, 9'd0);
    check("stall_level", level, 9'd5);

    // Flush with both entries full and a pop + issue pending
    flush = 1'b1; m_ready = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", m_valid, 1'b0);
    check("flush_rdptr", rd_ptr, 9'd5);
    check("flush_level", level, 9'd0);
    check("flush_addr", addr, 8'd5);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("flush_quiet", m_valid, 1'b0);
    end

    // Full-depth streaming from reset
    rst_n = 1'b0; wr_ptr = '0; m_ready = 1'b0;
    tick(); tick();
    rst_n = 1'b1; wr_ptr = 9'd256; m_ready = 1'b1;
    n = 0; first_c = -1;
    for (int c = 0; c < 300 && n < 256; c++) begin
      tick();
      if (m_valid) begin
        if (first_c < 0) first_c = c;
        check("stream_data", m_data, pat(n));
        n++;
      end else if (n > 0) begin
        check("stream_bubble", m_valid, 1'b1);
      end
    end
    check("stream_count", n, 256);
    check("stream_latency", first_c, 1);
    tick();
    check("stream_rdptr", rd_ptr, 9'h100);
    check("stream_valid_end", m_valid, 1'b0);
    check("stream_level_end", level, 9'd0);

    // Random backpressure with a bursty writer
    wn = 0; rn = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 20000 && rn < 1000; c++) begin
      tick();
      if (stalled) begin
        check("bp_hold_valid", m_valid, 1'b1);
        check("bp_hold_data", m_data, held);
      end
      m_ready = 1'($urandom_range(0, 1));
      used = wr_ptr - rd_ptr;
      if (wn < 1000 && used < 9'd256 && $urandom_range(0, 3) != 0) begin
        mem[wr_ptr[AW-1:0]] = pat(512 + wn);
        wr_ptr = wr_ptr + 1'b1;
        wn++;
      end
      if (m_valid && m_ready) begin
        check("bp_data", m_data, pat(512 + rn));
        rn++;
      end
      stalled = m_valid & ~m_ready;
      held    = m_data;
    end
    check("bp_count", rn, 1000);
    tick();
    m_ready = 1'b0;
    check("bp_rdptr", rd_ptr, 9'd232);
    check("bp_level", level, 9'd0);

    // Wrap across the top of the RAM
    wr_ptr = 9'd250; flush = 1'b1;
    tick();
    flush = 1'b0;
    check("wrap_start_rdptr", rd_ptr, 9'd250);
    check("wrap_start_addr", addr, 8'd250);
    for (int j = 0; j < 12; j++) mem[(250 + j) % 256] = pat(2000 + j);
    wr_ptr = 9'd262; m_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 12; c++) begin
      tick();
      if (m_valid) begin
        check("wrap_data", m_data, pat(2000 + n));
        n++;
      end else if (n > 0) begin
        check("wrap_bubble", m_valid, 1'b1);
      end
    end
    check("wrap_count", n, 12);
    tick();
    check("wrap_rdptr", rd_ptr, 9'd262);

    // Trickle: one word every third cycle
    for (int w = 0; w < 5; w++) begin
      tick();
      mem[wr_ptr[AW-1:0]] = pat(3000 + w);
      wr_ptr = wr_ptr + 1'b1;
      check("trickle_c0", m_valid, 1'b0);
      tick();
      check("trickle_c1", m_valid, 1'b0);
      tick();
      check("trickle_c2", m_valid, 1'b1);
      check("trickle_data", m_data, pat(3000 + w));
    end
    tick();
    check("trickle_end_valid", m_valid, 1'b0);
    check("trickle_rdptr", rd_ptr, 9'd267);

    // Reset mid-stream discards buffered data
    m_ready = 1'b0;
    wr_ptr = wr_ptr + 9'd3;
    tick(); tick(); tick();
    check("midrst_pre_valid", m_valid, 1'b1);
    rst_n = 1'b0;
    tick(); tick();
    check("midrst_valid", m_valid, 1'b0);
    check("midrst_rdptr", rd_ptr, 9'd0);
    check("midrst_addr", addr, 8'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
